// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: state encoding, flag bit, size codes, uop payload.
package wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned ZF_BIT = 6;

  localparam logic [SIZE_W-1:0] SZ8  = 2'd0;
  localparam logic [SIZE_W-1:0] SZ16 = 2'd1;
  localparam logic [SIZE_W-1:0] SZ32 = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RETIRE  = 2'd1,
    WAIT_DC = 2'd2
  } wb_state_e;

  // Contents of the EX/WB latches
  typedef struct packed {
    logic              v;
    logic [XLEN-1:0]   neip;
    logic [SIZE_W-1:0] size;
    logic              ld_gpr1;
    logic              ld_gpr2;
    logic              store;
    logic              repne;
    logic [XLEN-1:0]   res_a;
    logic [XLEN-1:0]   res_b;
    logic [XLEN-1:0]   flags;
    logic [REG_W-1:0]  dr1;
    logic [REG_W-1:0]  dr2;
    logic [XLEN-1:0]   addr;
  } wb_uop_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Execute->writeback bundle plus the dcache store handshake.
interface writeback_stage_if;
  import wb_pkg::*;

  logic              WB_ld_latches;
  logic              WB_V_next;
  logic [XLEN-1:0]   WB_NEIP_next;
  logic [SIZE_W-1:0] WB_d2_datasize_all_next;
  logic              WB_ex_ld_gpr1_wb_next;
  logic              WB_ex_ld_gpr2_wb_next;
  logic              WB_ex_dcache_write_wb_next;
  logic              WB_d2_repne_wb_next;
  logic [XLEN-1:0]   WB_RESULT_A_next;
  logic [XLEN-1:0]   WB_RESULT_B_next;
  logic [XLEN-1:0]   WB_FLAGS_next;
  logic [REG_W-1:0]  WB_DR1_next;
  logic [REG_W-1:0]  WB_DR2_next;
  logic [XLEN-1:0]   WB_ADDRESS_next;
  logic              WB_stall;

  logic              dcache_wr_req;
  logic [XLEN-1:0]   dcache_wr_addr;
  logic [XLEN-1:0]   dcache_wr_data;
  logic [SIZE_W-1:0] dcache_wr_size;
  logic              dcache_wr_ready;

  modport master (
    output WB_ld_latches, WB_V_next, WB_NEIP_next, WB_d2_datasize_all_next,
           WB_ex_ld_gpr1_wb_next, WB_ex_ld_gpr2_wb_next, WB_ex_dcache_write_wb_next,
           WB_d2_repne_wb_next, WB_RESULT_A_next, WB_RESULT_B_next, WB_FLAGS_next,
           WB_DR1_next, WB_DR2_next, WB_ADDRESS_next, dcache_wr_ready,
    input  WB_stall, dcache_wr_req, dcache_wr_addr, dcache_wr_data, dcache_wr_size
  );

  modport slave (
    input  WB_ld_latches, WB_V_next, WB_NEIP_next, WB_d2_datasize_all_next,
           WB_ex_ld_gpr1_wb_next, WB_ex_ld_gpr2_wb_next, WB_ex_dcache_write_wb_next,
           WB_d2_repne_wb_next, WB_RESULT_A_next, WB_RESULT_B_next, WB_FLAGS_next,
           WB_DR1_next, WB_DR2_next, WB_ADDRESS_next, dcache_wr_ready,
    output WB_stall, dcache_wr_req, dcache_wr_addr, dcache_wr_data, dcache_wr_size
  );

endinterface

// File: rtl/wb_dcache_wr_ctrl.sv
// Stage sequencing: holds a store request until dcache ready, generates stall, latch enable and retire.
module wb_dcache_wr_ctrl
  import wb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ld_latches_i,
  input  logic v_next_i,
  input  logic store_next_i,
  input  logic wr_ready_i,
  output logic latch_en_c,
  output logic retire_c,
  output logic stall_c,
  output logic wr_req_o
);

  wb_state_e state_q, state_d;
  logic      wr_req_q;

  // A store retires in the cycle ready is seen, so stall drops in that same cycle
  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    retire_c   = 1'b0;
    latch_en_c = 1'b0;
    case (state_q)
      IDLE:    state_d = IDLE;
      RETIRE:  retire_c = 1'b1;
      WAIT_DC: begin
        stall_c  = !wr_ready_i;
        retire_c = wr_ready_i;
      end
      default: state_d = IDLE;
    endcase
    latch_en_c = ld_latches_i && !stall_c;
    if (latch_en_c) begin
      if (!v_next_i)        state_d = IDLE;
      else if (store_next_i) state_d = WAIT_DC;
      else                  state_d = RETIRE;
    end else if (retire_c) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_req_q <= (state_d == WAIT_DC);
    end
  end

  assign wr_req_o = wr_req_q;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: EX/WB latches, retire decode, REPNE termination and retired-uop counter.
module writeback_stage
  import wb_pkg::wb_uop_t, wb_pkg::XLEN, wb_pkg::REG_W, wb_pkg::SIZE_W;
#(
  parameter int unsigned ZF_BIT = wb_pkg::ZF_BIT,
  parameter int unsigned CNT_W  = 32
) (
  input  logic               CLK,
  input  logic               CLR,
  writeback_stage_if.slave   wb,
  output logic               gpr1_we,
  output logic               gpr2_we,
  output logic [REG_W-1:0]   gpr1_sel,
  output logic [REG_W-1:0]   gpr2_sel,
  output logic [XLEN-1:0]    gpr1_data,
  output logic [XLEN-1:0]    gpr2_data,
  output logic [SIZE_W-1:0]  gpr_size,
  output logic               flags_we,
  output logic [XLEN-1:0]    flags_data,
  output logic               eip_we,
  output logic [XLEN-1:0]    eip_data,
  output logic               wb_repne_terminate_all,
  output logic [CNT_W-1:0]   retire_count
);

  wb_uop_t          uop_q, uop_d, uop_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latch_en, retire, wr_req, retire_v;
  logic             collide, repne_done;

  wb_dcache_wr_ctrl u_dc_ctrl (
    .clk          (CLK),
    .rst_n        (CLR),
    .ld_latches_i (wb.WB_ld_latches),
    .v_next_i     (wb.WB_V_next),
    .store_next_i (wb.WB_ex_dcache_write_wb_next),
    .wr_ready_i   (wb.dcache_wr_ready),
    .latch_en_c   (latch_en),
    .retire_c     (retire),
    .stall_c      (wb.WB_stall),
    .wr_req_o     (wr_req)
  );

  always_comb begin
    uop_next         = '0;
    uop_next.v       = wb.WB_V_next;
    uop_next.neip    = wb.WB_NEIP_next;
    uop_next.size    = wb.WB_d2_datasize_all_next;
    uop_next.ld_gpr1 = wb.WB_ex_ld_gpr1_wb_next;
    uop_next.ld_gpr2 = wb.WB_ex_ld_gpr2_wb_next;
    uop_next.store   = wb.WB_ex_dcache_write_wb_next;
    uop_next.repne   = wb.WB_d2_repne_wb_next;
    uop_next.res_a   = wb.WB_RESULT_A_next;
    uop_next.res_b   = wb.WB_RESULT_B_next;
    uop_next.flags   = wb.WB_FLAGS_next;
    uop_next.dr1     = wb.WB_DR1_next;
    uop_next.dr2     = wb.WB_DR2_next;
    uop_next.addr    = wb.WB_ADDRESS_next;
  end

  assign uop_d = latch_en ? uop_next : uop_q;

  // Retire is all-or-nothing; a same-register double write keeps only GPR1
  assign retire_v   = retire && uop_q.v;
  assign collide    = uop_q.ld_gpr1 && uop_q.ld_gpr2 && (uop_q.dr1 == uop_q.dr2);
  assign repne_done = uop_q.repne && ((uop_q.res_b == '0) || uop_q.flags[ZF_BIT]);
  assign cnt_d      = cnt_q + CNT_W'(retire_v);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      uop_q <= '0;
      cnt_q <= '0;
    end else begin
      uop_q <= uop_d;
      cnt_q <= cnt_d;
    end
  end

  assign gpr1_we                = retire_v && uop_q.ld_gpr1;
  assign gpr2_we                = retire_v && uop_q.ld_gpr2 && !collide;
  assign flags_we               = retire_v;
  assign eip_we                 = retire_v && (!uop_q.repne || repne_done);
  assign wb_repne_terminate_all = retire_v && repne_done;

  assign gpr1_sel   = uop_q.dr1;
  assign gpr2_sel   = uop_q.dr2;
  assign gpr1_data  = uop_q.res_a;
  assign gpr2_data  = uop_q.res_b;
  assign gpr_size   = uop_q.size;
  assign flags_data = uop_q.flags;
  assign eip_data   = uop_q.neip;

  assign wb.dcache_wr_req  = wr_req && uop_q.store;
  assign wb.dcache_wr_addr = uop_q.addr;
  assign wb.dcache_wr_data = uop_q.res_a;
  assign wb.dcache_wr_size = uop_q.size;

  assign retire_count = cnt_q;

endmodule
